// File: rtl/n64_pi_address_latch.sv
// N64 parallel-interface address latch: captures the ALE_H/ALE_L address
// phase, then tracks the auto-incrementing address across read/write cycles.
module n64_pi_address_latch (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_n64_ale_h,
    input  logic        i_n64_ale_l,
    input  logic        i_n64_read,
    input  logic        i_n64_write,
    input  logic [15:0] i_n64_ad,
    output logic [31:0] o_address,
    output logic        o_address_valid,
    output logic        o_start,
    output logic        o_read_strobe,
    output logic        o_write_strobe,
    output logic [15:0] o_wdata,
    output logic        o_error
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR_HIGH,
        ADDR_LOW,
        DATA
    } state_t;

    state_t      state_q, state_d;
    logic        ale_h_q, ale_l_q, read_q, write_q;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        start_q, start_d;
    logic        rstb_q, rstb_d;
    logic        wstb_q, wstb_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;

    logic ale_h_fall, ale_l_fall;
    logic rd_fall, rd_rise, wr_rise;
    logic both_low, both_low_q, conflict;
    logic restart, rd_inc;

    assign ale_h_fall = ale_h_q & ~i_n64_ale_h;
    assign ale_l_fall = ale_l_q & ~i_n64_ale_l;
    assign rd_fall    = read_q & ~i_n64_read;
    assign rd_rise    = ~read_q & i_n64_read;
    assign wr_rise    = ~write_q & i_n64_write;
    assign both_low   = ~i_n64_read & ~i_n64_write;
    assign both_low_q = ~read_q & ~write_q;
    // Edges entering or leaving a read/write overlap are not real cycles.
    assign conflict   = both_low | both_low_q;
    assign restart    = i_n64_ale_h & i_n64_ale_l & (state_q != ADDR_HIGH);
    assign rd_inc     = rd_rise & ~conflict;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        start_d = 1'b0;
        rstb_d  = 1'b0;
        wstb_d  = 1'b0;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        pend_d  = 1'b0;
        if (restart) begin
            state_d = ADDR_HIGH;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ADDR_HIGH: begin
                    if (ale_h_fall && i_n64_ale_l) begin
                        addr_d[31:16] = i_n64_ad;
                        state_d       = ADDR_LOW;
                    end else if (ale_l_fall) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                ADDR_LOW: begin
                    if (ale_l_fall) begin
                        addr_d[15:0] = {i_n64_ad[15:1], 1'b0};
                        valid_d      = 1'b1;
                        start_d      = 1'b1;
                        state_d      = DATA;
                    end
                end
                DATA: begin
                    err_d = both_low & ~both_low_q;
                    if (!conflict) begin
                        if (wr_rise) begin
                            wdata_d = i_n64_ad;
                            wstb_d  = 1'b1;
                            pend_d  = 1'b1;
                        end else if (rd_fall) begin
                            rstb_d = 1'b1;
                        end
                    end
                    // Write increments one cycle late so the strobe sees its address.
                    addr_d = addr_q + {30'd0, pend_q, 1'b0}
                                    + {30'd0, rd_inc, 1'b0};
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            ale_h_q <= 1'b0;
            ale_l_q <= 1'b0;
            read_q  <= 1'b1;
            write_q <= 1'b1;
            addr_q  <= 32'd0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            rstb_q  <= 1'b0;
            wstb_q  <= 1'b0;
            wdata_q <= 16'd0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ale_h_q <= i_n64_ale_h;
            ale_l_q <= i_n64_ale_l;
            read_q  <= i_n64_read;
            write_q <= i_n64_write;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            start_q <= start_d;
            rstb_q  <= rstb_d;
            wstb_q  <= wstb_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign o_address       = addr_q;
    assign o_address_valid = valid_q;
    assign o_start         = start_q;
    assign o_read_strobe   = rstb_q;
    assign o_write_strobe  = wstb_q;
    assign o_wdata         = wdata_q;
    assign o_error         = err_q;

endmodule

// File: tb/tb_n64_pi_address_latch.sv
// Self-checking bench for n64_pi_address_latch: directed protocol cases
// plus randomized bursts against an address-arithmetic reference.
module tb_n64_pi_address_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ale_h, ale_l, rd_n, wr_n;
    logic [15:0] ad;
    logic [31:0] address;
    logic        valid, start, rstb, wstb, err;
    logic [15:0] wdata;

    int n_checks = 0;
    int n_fail   = 0;

    n64_pi_address_latch dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_n64_ale_h    (ale_h),
        .i_n64_ale_l    (ale_l),
        .i_n64_read     (rd_n),
        .i_n64_write    (wr_n),
        .i_n64_ad       (ad),
        .o_address      (address),
        .o_address_valid(valid),
        .o_start        (start),
        .o_read_strobe  (rstb),
        .o_write_strobe (wstb),
        .o_wdata        (wdata),
        .o_error        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ($countones({start, rstb, wstb}) > 1) begin
                n_fail++;
                $display("FAIL exclusive start/rd/wr got %b%b%b", start, rstb, wstb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_addr(input logic [31:0] a, output logic s1,
                           output logic v1, output logic [31:0] a1,
                           output logic s2);
        ale_h = 1'b1; ale_l = 1'b1; step();
        ad = a[31:16]; step();
        ale_h = 1'b0; step();
        ad = a[15:0]; step();
        ale_l = 1'b0; step();
        s1 = start; v1 = valid; a1 = address;
        step();
        s2 = start;
    endtask

    task automatic do_read(output logic s1, output logic [31:0] a1,
                           output logic s2, output logic [31:0] a2);
        rd_n = 1'b0; step();
        s1 = rstb; a1 = address;
        step();
        s2 = rstb;
        rd_n = 1'b1; step();
        a2 = address;
    endtask

    task automatic do_write(input logic [15:0] d, output logic s1,
                            output logic [31:0] a1, output logic [15:0] w1,
                            output logic s2, output logic [31:0] a2);
        ad = d; wr_n = 1'b0; step();
        step();
        wr_n = 1'b1; step();
        s1 = wstb; a1 = address; w1 = wdata;
        step();
        s2 = wstb; a2 = address;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        n_checks++; if ({address, valid, start, rstb, wstb, wdata, err} !== 53'd0) begin
            n_fail++; $display("FAIL reset outputs got %h exp 0", {address, valid, start, rstb, wstb, wdata, err});
        end
        rst = 1'b0; step();
        n_checks++; if ({start, rstb, wstb, err} !== 4'd0) begin
            n_fail++; $display("FAIL post_reset pulses got %b exp 0000", {start, rstb, wstb, err});
        end
    endtask

    task automatic test_addr_phase();
        logic s1, v1, s2;
        logic [31:0] a1;
        do_addr(32'h1000_0041, s1, v1, a1, s2);
        n_checks++; if (a1 !== 32'h1000_0040) begin
            n_fail++; $display("FAIL addr_phase address got %h exp 10000040", a1);
        end
        n_checks++; if ({s1, v1, s2} !== 3'b110) begin
            n_fail++; $display("FAIL addr_phase start/valid/start2 got %b exp 110", {s1, v1, s2});
        end
    endtask

    task automatic test_read_burst();
        logic s1, s2;
        logic [31:0] a1, a2;
        for (int i = 0; i < 4; i++) begin
            do_read(s1, a1, s2, a2);
            n_checks++; if ({s1, s2} !== 2'b10 || a1 !== 32'h1000_0040 + 32'(2 * i)) begin
                n_fail++; $display("FAIL read_burst[%0d] strobe %b addr %h exp 10 %h", i, {s1, s2}, a1, 32'h1000_0040 + 32'(2 * i));
            end
        end
        n_checks++; if (a2 !== 32'h1000_0048) begin
            n_fail++; $display("FAIL read_burst final got %h exp 10000048", a2);
        end
    endtask

    task automatic test_write();
        logic s1, v1, s2;
        logic [31:0] a1, a2;
        logic [15:0] w1;
        do_addr(32'h1D00_0000, s1, v1, a1, s2);
        do_write(16'hBEEF, s1, a1, w1, s2, a2);
        n_checks++; if ({s1, s2} !== 2'b10 || w1 !== 16'hBEEF || a1 !== 32'h1D00_0000) begin
            n_fail++; $display("FAIL write strobe %b wdata %h addr %h exp 10 beef 1d000000", {s1, s2}, w1, a1);
        end
        n_checks++; if (a2 !== 32'h1D00_0002) begin
            n_fail++; $display("FAIL write next_addr got %h exp 1d000002", a2);
        end
    endtask

    task automatic test_wrap();
        logic s1, v1, s2;
        logic [31:0] a1, a2;
        do_addr(32'hFFFF_FFFE, s1, v1, a1, s2);
        do_read(s1, a1, s2, a2);
        n_checks++; if (a1 !== 32'hFFFF_FFFE || a2 !== 32'h0) begin
            n_fail++; $display("FAIL wrap got %h->%h exp fffffffe->00000000", a1, a2);
        end
    endtask

    task automatic test_errors();
        logic s1, v1, s2;
        logic [31:0] a1;
        do_addr(32'h0400_0010, s1, v1, a1, s2);
        rd_n = 1'b0; wr_n = 1'b0; step();
        n_checks++; if ({err, rstb, wstb} !== 3'b100 || address !== 32'h0400_0010) begin
            n_fail++; $display("FAIL rw_conflict err/rs/ws %b addr %h exp 100 04000010", {err, rstb, wstb}, address);
        end
        step();
        n_checks++; if (err !== 1'b0) begin
            n_fail++; $display("FAIL rw_conflict pulse_width got %b exp 0", err);
        end
        rd_n = 1'b1; wr_n = 1'b1; step(); step();
        n_checks++; if ({rstb, wstb} !== 2'b00 || address !== 32'h0400_0010) begin
            n_fail++; $display("FAIL rw_release strobes %b addr %h exp 00 04000010", {rstb, wstb}, address);
        end
        ale_h = 1'b1; ale_l = 1'b1; step();
        ale_l = 1'b0; step();
        n_checks++; if (err !== 1'b1) begin
            n_fail++; $display("FAIL ale_l_early err got %b exp 1", err);
        end
        ale_h = 1'b0; step();
        ale_l = 1'b1; step();
        ale_l = 1'b0; step(); step();
        n_checks++; if ({err, start, valid} !== 3'b000) begin
            n_fail++; $display("FAIL ale_l_early idle err/start/valid %b exp 000", {err, start, valid});
        end
    endtask

    task automatic test_abort();
        logic s1, v1, s2;
        logic [31:0] a1;
        do_addr(32'h0800_0100, s1, v1, a1, s2);
        rd_n = 1'b0; step();
        ale_h = 1'b1; ale_l = 1'b1; step();
        n_checks++; if (valid !== 1'b0 || address !== 32'h0800_0100) begin
            n_fail++; $display("FAIL abort_read valid %b addr %h exp 0 08000100", valid, address);
        end
        rd_n = 1'b1; step(); step();
        n_checks++; if (address !== 32'h0800_0100 || rstb !== 1'b0) begin
            n_fail++; $display("FAIL abort_read no_inc addr %h rs %b exp 08000100 0", address, rstb);
        end
        do_addr(32'h0800_0200, s1, v1, a1, s2);
        ad = 16'h1234; wr_n = 1'b0; step();
        ale_h = 1'b1; ale_l = 1'b1; step();
        wr_n = 1'b1; step(); step();
        n_checks++; if (wstb !== 1'b0 || valid !== 1'b0 || address !== 32'h0800_0200) begin
            n_fail++; $display("FAIL abort_write ws %b valid %b addr %h exp 0 0 08000200", wstb, valid, address);
        end
        do_addr(32'h0800_0300, s1, v1, a1, s2);
        rd_n = 1'b0; step();
        rst = 1'b1; step();
        n_checks++; if ({address, valid, start, rstb, wstb, wdata, err} !== 53'd0) begin
            n_fail++; $display("FAIL reset_mid_burst got %h exp 0", {address, valid, start, rstb, wstb, wdata, err});
        end
        rd_n = 1'b1; rst = 1'b0; step();
        n_checks++; if ({start, rstb, wstb, err, valid} !== 5'd0) begin
            n_fail++; $display("FAIL reset_release pulses got %b exp 00000", {start, rstb, wstb, err, valid});
        end
    endtask

    task automatic test_random();
        logic s1, v1, s2;
        logic [31:0] a1, a2, base, exp_addr;
        logic [15:0] w1, d;
        for (int t = 0; t < 12; t++) begin
            base = $urandom;
            if ($urandom_range(3) == 0) base = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            exp_addr = {base[31:1], 1'b0};
            do_addr(base, s1, v1, a1, s2);
            n_checks++; if ({s1, v1} !== 2'b11 || a1 !== exp_addr) begin
                n_fail++; $display("FAIL rand_addr[%0d] start/valid %b addr %h exp 11 %h", t, {s1, v1}, a1, exp_addr);
            end
            for (int k = 0; k < int'($urandom_range(5, 1)); k++) begin
                if ($urandom_range(1) == 1) begin
                    d = 16'($urandom);
                    do_write(d, s1, a1, w1, s2, a2);
                    n_checks++; if ({s1, s2} !== 2'b10 || a1 !== exp_addr || w1 !== d) begin
                        n_fail++; $display("FAIL rand_write[%0d.%0d] ws %b addr %h wd %h exp 10 %h %h", t, k, {s1, s2}, a1, w1, exp_addr, d);
                    end
                end else begin
                    do_read(s1, a1, s2, a2);
                    n_checks++; if ({s1, s2} !== 2'b10 || a1 !== exp_addr) begin
                        n_fail++; $display("FAIL rand_read[%0d.%0d] rs %b addr %h exp 10 %h", t, k, {s1, s2}, a1, exp_addr);
                    end
                end
                exp_addr = exp_addr + 32'd2;
                n_checks++; if (a2 !== exp_addr) begin
                    n_fail++; $display("FAIL rand_inc[%0d.%0d] got %h exp %h", t, k, a2, exp_addr);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ale_h = 1'b0; ale_l = 1'b0;
        rd_n = 1'b1; wr_n = 1'b1; ad = 16'h0;
        test_reset();
        test_addr_phase();
        test_read_burst();
        test_write();
        test_wrap();
        test_errors();
        test_abort();
        test_random();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
